// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: funct3 size codes, FSM states,
// and the request-legality helper used at the access edge.
package dmem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Unsigned sizes only make sense for loads; 011/110/111 are never legal.
  function automatic logic size_illegal(input logic [2:0] size, input logic write);
    case (size)
      SZ_B, SZ_H, SZ_W: size_illegal = 1'b0;
      SZ_BU, SZ_HU:     size_illegal = write;
      default:          size_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/halfword lane steering: extends load data out of a word and merges
// low-aligned store data into the addressed lanes of the old word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_size,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_wword,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte     = i_word[{i_addr, 3'b000} +: 8];
    w_half     = i_addr[1] ? i_word[31:16] : i_word[15:0];
    o_rdata    = '0;
    o_wword    = i_word;
    o_misalign = 1'b0;
    case (i_size)
      SZ_B, SZ_BU: begin
        o_rdata = (i_size == SZ_B) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
        o_wword[{i_addr, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_H, SZ_HU: begin
        o_misalign = i_addr[0];
        o_rdata = (i_size == SZ_H) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
        o_wword[{i_addr[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      SZ_W: begin
        o_misalign = |i_addr;
        o_rdata    = i_word;
        o_wword    = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's load/store port: one request at a time,
// LATENCY cycles to the access edge, response held until accepted.
// Build option: define DMEM_INIT_EN to preload the array at time 0.
//
// Handshakes: a transfer happens on a rising CLK edge where VALID and READY are
// both 1; VALID never waits on READY, and once RSP_VALID rises its payload holds
// until the edge that accepts it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [2:0]  REQ_SIZE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic [1:0]  o_dbg_state
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_WAIT   = WAIT;
  localparam logic [1:0] S_RESP   = RESP;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [2:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_word;
  logic [31:0]      w_rdata;
  logic [31:0]      w_wword;
  logic             w_misalign;
  logic             w_range_err;
  logic             w_err;
  logic             w_access;

`ifdef DMEM_INIT_EN
  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] = 32'd0;
  end
`else
  // No preload: words read as X until first written.
`endif

  assign w_idx       = r_addr[IDX_W+1:2];
  assign w_word      = r_mem[w_idx];
  assign w_range_err = {2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign w_err       = w_misalign | w_range_err | size_illegal(r_size, r_write);
  assign w_access    = (r_state == S_WAIT) && (r_cnt == 4'd0);

  dmem_lane_align u_align (
    .i_word     (w_word),
    .i_addr     (r_addr[1:0]),
    .i_size     (r_size),
    .i_wdata    (r_wdata),
    .o_rdata    (w_rdata),
    .o_wword    (w_wword),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (REQ_VALID) begin
          r_state <= S_WAIT;
          r_cnt   <= CNT_INIT;
        end
        S_WAIT: if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_state     <= S_RESP;
          r_rsp_err   <= w_err;
          r_rsp_rdata <= (w_err || r_write) ? 32'd0 : w_rdata;
        end
        S_RESP: if (RSP_READY) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request fields are frozen at acceptance so later input changes are ignored.
  always_ff @(posedge CLK) begin
    if (!RESET && r_state == S_IDLE && REQ_VALID) begin
      r_write <= REQ_WRITE;
      r_size  <= REQ_SIZE;
      r_addr  <= REQ_ADDR;
      r_wdata <= REQ_WDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && w_access && r_write && !w_err) r_mem[w_idx] <= w_wword;
  end

  assign REQ_READY   = (r_state == S_IDLE) && !RESET;
  assign RSP_VALID   = (r_state == S_RESP) && !RESET;
  assign RSP_RDATA   = RSP_VALID ? r_rsp_rdata : 32'd0;
  assign RSP_ERR     = RSP_VALID && r_rsp_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY=4: word and lane loads/stores,
// error cases, response backpressure, and reset in WAIT and RESP.
module tb_dmem_responder;

  localparam int LAT   = 4;
  localparam int DEPTH = 64;

  logic        CLK;
  logic        RESET;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic [2:0]  REQ_SIZE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .REQ_VALID   (REQ_VALID),
    .REQ_READY   (REQ_READY),
    .REQ_WRITE   (REQ_WRITE),
    .REQ_SIZE    (REQ_SIZE),
    .REQ_ADDR    (REQ_ADDR),
    .REQ_WDATA   (REQ_WDATA),
    .RSP_VALID   (RSP_VALID),
    .RSP_READY   (RSP_READY),
    .RSP_RDATA   (RSP_RDATA),
    .RSP_ERR     (RSP_ERR),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Driver tasks: handshake finishes one negedge after the accepting edge.
  task automatic send_req(input logic w, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] d, output logic ok);
    int n;
    n = 0;
    @(negedge CLK);
    REQ_WRITE = w; REQ_SIZE = sz; REQ_ADDR = a; REQ_WDATA = d; REQ_VALID = 1'b1;
    while (!REQ_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    ok = REQ_READY;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    REQ_WRITE = ~w; REQ_SIZE = 3'b111; REQ_ADDR = 32'hFFFF_FFFF; REQ_WDATA = 32'h0;
  endtask

  // lat counts negedges from the handshake cycle to the first one showing RSP_VALID.
  task automatic wait_rsp(output logic [31:0] rdata, output logic err, output int lat);
    int c;
    c = 1;
    while (!RSP_VALID && c < 40) begin
      @(negedge CLK);
      c++;
    end
    lat = c; rdata = RSP_RDATA; err = RSP_ERR;
  endtask

  task automatic ack_rsp();
    RSP_READY = 1'b1;
    @(negedge CLK);
    RSP_READY = 1'b0;
  endtask

  task automatic xact(input logic w, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rdata,
                      output logic err, output int lat);
    logic ok;
    send_req(w, sz, a, d, ok);
    wait_rsp(rdata, err, lat);
    if (!ok) lat = -1;
    ack_rsp();
  endtask

  // Scenarios
  task automatic test_reset();
    RESET = 1'b1; REQ_VALID = 1'b0; RSP_READY = 1'b0;
    REQ_WRITE = 1'b0; REQ_SIZE = 3'b010; REQ_ADDR = '0; REQ_WDATA = '0;
    repeat (3) @(negedge CLK);
    total++; if (REQ_READY !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", REQ_READY); end
    total++; if (RSP_VALID !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", RSP_VALID); end
    total++; if (RSP_RDATA !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", RSP_RDATA); end
    total++; if (RSP_ERR !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", RSP_ERR); end
    RESET = 1'b0;
    #1;
    total++; if (REQ_READY !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", REQ_READY); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
    total++; if (lat !== LAT + 1) begin bad++; $display("FAIL sw_latency got=%0d exp=%0d", lat, LAT + 1); end
    total++; if (rd !== 32'd0 || er !== 1'b0) begin bad++; $display("FAIL sw_rsp got=%h/%b exp=0/0", rd, er); end
    total++; if (REQ_READY !== 1'b1) begin bad++; $display("FAIL sw_idle_after_ack got=%b exp=1", REQ_READY); end
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    total++; if (lat !== LAT + 1) begin bad++; $display("FAIL lw_latency got=%0d exp=%0d", lat, LAT + 1); end
    total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL lw_rsp got=%h/%b exp=deadbeef/0", rd, er); end
    xact(1'b1, 3'b010, 32'hFC, 32'hCAFEF00D, rd, er, lat);
    xact(1'b0, 3'b010, 32'hFC, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin bad++; $display("FAIL last_word got=%h/%b exp=cafef00d/0", rd, er); end
    xact(1'b1, 3'b010, 32'h0, 32'h00C0FFEE, rd, er, lat);
  endtask

  task automatic test_lanes();
    logic [2:0]  sz_t[8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ad_t[8] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h11, 32'h10, 32'h10, 32'h12};
    logic [31:0] rd; logic er; int lat;
    exp_q = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF,
              32'hFFFFFFBE, 32'h000000EF, 32'hFFFFBEEF, 32'h0000DEAD};
    for (int i = 0; i < 8; i++) begin
      xact(1'b0, sz_t[i], ad_t[i], 32'h0, rd, er, lat);
      total++;
      if (rd !== exp_q[0] || er !== 1'b0)
        begin bad++; $display("FAIL lane_load%0d got=%h/%b exp=%h/0", i, rd, er, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_store_lanes();
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, 3'b000, 32'h11, 32'hFFFFFF55, rd, er, lat);
    total++; if (rd !== 32'd0 || er !== 1'b0) begin bad++; $display("FAIL sb_rsp got=%h/%b exp=0/0", rd, er); end
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hDEAD55EF) begin bad++; $display("FAIL sb_merge got=%h exp=dead55ef", rd); end
    xact(1'b1, 3'b001, 32'h12, 32'hABCD1234, rd, er, lat);
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h123455EF) begin bad++; $display("FAIL sh_merge got=%h exp=123455ef", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    xact(1'b0, 3'b010, 32'h12, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL lw_misalign got=%h/%b exp=0/1", rd, er); end
    total++; if (lat !== LAT + 1) begin bad++; $display("FAIL err_latency got=%0d exp=%0d", lat, LAT + 1); end
    xact(1'b1, 3'b010, 32'h100, 32'h11111111, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL sw_range got=%h/%b exp=0/1", rd, er); end
    xact(1'b0, 3'b010, 32'h0, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h00C0FFEE || er !== 1'b0) begin bad++; $display("FAIL range_no_alias got=%h/%b exp=00c0ffee/0", rd, er); end
    xact(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL size011 got=%h/%b exp=0/1", rd, er); end
    xact(1'b1, 3'b100, 32'h10, 32'h77, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL store_bu got=%b exp=1", er); end
    xact(1'b1, 3'b001, 32'h11, 32'h9999, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL sh_misalign got=%b exp=1", er); end
    xact(1'b0, 3'b001, 32'h13, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL lh_misalign got=%h/%b exp=0/1", rd, er); end
    xact(1'b0, 3'b010, 32'h80000010, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL high_addr got=%b exp=1", er); end
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h123455EF || er !== 1'b0) begin bad++; $display("FAIL err_no_write got=%h/%b exp=123455ef/0", rd, er); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; logic ok;
    send_req(1'b0, 3'b010, 32'h10, 32'h0, ok);
    wait_rsp(rd, er, lat);
    total++; if (lat !== LAT + 1) begin bad++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT + 1); end
    REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_SIZE = 3'b010; REQ_ADDR = 32'h10; REQ_WDATA = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      total++;
      if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'h123455EF || RSP_ERR !== 1'b0 || REQ_READY !== 1'b0)
        begin bad++; $display("FAIL bp_hold%0d got=%b/%h/%b/%b exp=1/123455ef/0/0", i, RSP_VALID, RSP_RDATA, RSP_ERR, REQ_READY); end
    end
    REQ_VALID = 1'b0;
    ack_rsp();
    total++; if (REQ_READY !== 1'b1 || RSP_VALID !== 1'b0) begin bad++; $display("FAIL bp_release got=%b/%b exp=1/0", REQ_READY, RSP_VALID); end
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h123455EF) begin bad++; $display("FAIL bp_ignored_req got=%h exp=123455ef", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; logic ok; int seen;
    xact(1'b1, 3'b010, 32'h20, 32'h0BADF00D, rd, er, lat);
    send_req(1'b1, 3'b010, 32'h20, 32'hA5A5A5A5, ok);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    total++;
    if (REQ_READY !== 1'b0 || RSP_VALID !== 1'b0 || RSP_RDATA !== 32'd0 || RSP_ERR !== 1'b0)
      begin bad++; $display("FAIL wait_rst_outs got=%b/%b/%h/%b exp=0/0/0/0", REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR); end
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    total++; if (REQ_READY !== 1'b1) begin bad++; $display("FAIL wait_rst_ready got=%b exp=1", REQ_READY); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (RSP_VALID !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL wait_rst_dropped got=%0d exp=0", seen); end
    xact(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin bad++; $display("FAIL wait_rst_no_write got=%h/%b exp=0badf00d/0", rd, er); end
    send_req(1'b0, 3'b010, 32'h10, 32'h0, ok);
    wait_rsp(rd, er, lat);
    RESET = 1'b1;
    #1;
    total++; if (RSP_VALID !== 1'b0 || RSP_RDATA !== 32'd0) begin bad++; $display("FAIL resp_rst_outs got=%b/%h exp=0/0", RSP_VALID, RSP_RDATA); end
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    total++; if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1) begin bad++; $display("FAIL resp_rst_dropped got=%b/%b exp=0/1", RSP_VALID, REQ_READY); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_store_lanes();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
